regfile_2w_sb: RTL and testbench

- Parametrised successor to the single-cycle register file.
- Two synchronous write ports: port 0 for ALU writeback, port 1 for load writeback.
- Two combinational read ports with optional same-cycle write bypass.
- Per-register pending scoreboard so multi-cycle producers (loads) can stall dependent readers.
- Sits between decode (reads/claims) and the writeback stages of the multi-cycle/pipelined datapath.

---
 rtl/regfile_2w_sb.sv | 149 ++++++++++++++
 tb/tb_regfile_2w_sb.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_2w_sb.sv
// regfile_2w_sb
//   Register file with two write ports, two combinational read ports and a
//   per-register pending scoreboard. Decode reads operands and claims the
//   destination of multi-cycle producers (loads); the writeback stages
//   commit results and release the claim.
//
// Parameters
//   DATA_W   register width in bits
//   ADDR_W   register index width, DEPTH = 2**ADDR_W
//   ZERO_REG 1: register 0 reads as zero and ignores writes and claims
//   BYPASS   1: reads see same-cycle write data (write-through)
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   ra1/ra2 -> rd1/rd2       read addresses and data
//   rdy1/rdy2                read data valid (no outstanding producer)
//   we0/wa0/wd0              write port 0 (ALU writeback)
//   we1/wa1/wd1              write port 1 (load writeback, wins collisions)
//   claim_en/claim_addr      mark a register pending
//   pend_cnt                 number of pending registers (registered)
module regfile_2w_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              rdy1,
  output logic              rdy2,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [ADDR_W:0]   pend_cnt_q, pend_cnt_d;

  logic we0_eff, we1_eff, claim_eff;
  logic [DATA_W:0] rp1, rp2;

  // Writes and claims aimed at the hardwired zero register are dropped here,
  // so neither the array nor the scoreboard ever records them.
  always_comb begin
    we0_eff   = we0;
    we1_eff   = we1;
    claim_eff = claim_en;
    if (ZERO_REG != 0) begin
      if (wa0 == '0)        we0_eff   = 1'b0;
      if (wa1 == '0)        we1_eff   = 1'b0;
      if (claim_addr == '0) claim_eff = 1'b0;
    end
  end

  // Returns {rdy, data} for one read port.
  function automatic logic [DATA_W:0] read_port(
    input logic [ADDR_W-1:0] ra,
    input logic [DATA_W-1:0] stored,
    input logic              pending,
    input logic              w0,
    input logic [ADDR_W-1:0] a0,
    input logic [DATA_W-1:0] d0,
    input logic              w1,
    input logic [ADDR_W-1:0] a1,
    input logic [DATA_W-1:0] d1
  );
    logic [DATA_W-1:0] data;
    logic              rdy;
    data = stored;
    rdy  = ~pending;
    if (BYPASS != 0) begin
      // Port 1 is checked first so it wins a same-address collision,
      // matching what the array will hold after the edge.
      if (w1 && (a1 == ra)) begin
        data = d1;
        rdy  = 1'b1;
      end else if (w0 && (a0 == ra)) begin
        data = d0;
        rdy  = 1'b1;
      end
    end
    if ((ZERO_REG != 0) && (ra == '0)) begin
      data = '0;
      rdy  = 1'b1;
    end
    return {rdy, data};
  endfunction

  always_comb begin
    rp1 = read_port(ra1, mem_q[ra1], pend_q[ra1], we0_eff, wa0, wd0, we1_eff, wa1, wd1);
    rp2 = read_port(ra2, mem_q[ra2], pend_q[ra2], we0_eff, wa0, wd0, we1_eff, wa1, wd1);
    // Held in reset, the bypass path must not leak write data to the outputs.
    rd1  = rst_n ? rp1[DATA_W-1:0] : '0;
    rd2  = rst_n ? rp2[DATA_W-1:0] : '0;
    rdy1 = ~rst_n | rp1[DATA_W];
    rdy2 = ~rst_n | rp2[DATA_W];
  end

  // Writes release a claim first; a claim in the same cycle then re-sets the
  // bit, because the newly issued producer is the one still outstanding.
  always_comb begin
    pend_d = pend_q;
    if (we0_eff)   pend_d[wa0]        = 1'b0;
    if (we1_eff)   pend_d[wa1]        = 1'b0;
    if (claim_eff) pend_d[claim_addr] = 1'b1;
    pend_cnt_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      pend_cnt_d = pend_cnt_d + {{ADDR_W{1'b0}}, pend_d[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  // Port 1 is written last so it overrides port 0 on an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (we0_eff) mem_q[wa0] <= wd0;
      if (we1_eff) mem_q[wa1] <= wd1;
    end
  end

  assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_regfile_2w_sb.sv
// tb_regfile_2w_sb
//   Drives two instances of regfile_2w_sb from the same stimulus: dut_a with
//   write bypass, dut_b without. Expected values come from a register-array
//   reference model that applies the architectural rules directly.
module tb_regfile_2w_sb;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] ra1, ra2, wa0, wa1, claim_addr;
  logic [DW-1:0] wd0, wd1;
  logic          we0, we1, claim_en;

  logic [DW-1:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic          rdy1_a, rdy2_a, rdy1_b, rdy2_b;
  logic [AW:0]   pc_a, pc_b;

  always #5 clk = ~clk;

  regfile_2w_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a),
    .rdy1(rdy1_a), .rdy2(rdy2_a), .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1), .claim_en(claim_en),
    .claim_addr(claim_addr), .pend_cnt(pc_a)
  );

  regfile_2w_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .rdy1(rdy1_b), .rdy2(rdy2_b), .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1), .claim_en(claim_en),
    .claim_addr(claim_addr), .pend_cnt(pc_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: architectural register contents and pending flags.
  logic [DW-1:0] m_mem  [DEPTH];
  bit            m_pend [DEPTH];

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  // Effect of one rising edge; register 0 is immune to writes and claims.
  task automatic model_edge();
    if (!rst_n) return;
    if (we0 && wa0 != 0) m_mem[wa0] = wd0;
    if (we1 && wa1 != 0) m_mem[wa1] = wd1;
    if (we0 && wa0 != 0) m_pend[wa0] = 1'b0;
    if (we1 && wa1 != 0) m_pend[wa1] = 1'b0;
    if (claim_en && claim_addr != 0) m_pend[claim_addr] = 1'b1;
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] ra, input bit bypass);
    if (!rst_n) return '0;
    if (ra == 0) return '0;
    if (bypass && we1 && wa1 == ra) return wd1;
    if (bypass && we0 && wa0 == ra) return wd0;
    return m_mem[ra];
  endfunction

  function automatic logic [DW-1:0] exp_rdy(input logic [AW-1:0] ra, input bit bypass);
    if (!rst_n) return 1;
    if (ra == 0) return 1;
    if (bypass && ((we1 && wa1 == ra) || (we0 && wa0 == ra))) return 1;
    return m_pend[ra] ? 0 : 1;
  endfunction

  function automatic logic [DW-1:0] exp_cnt();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_pend[i]);
    return DW'(n);
  endfunction

  task automatic check_all(input string tag);
    check_eq({tag, ".rd1a"},  rd1_a,           exp_rd(ra1, 1));
    check_eq({tag, ".rd2a"},  rd2_a,           exp_rd(ra2, 1));
    check_eq({tag, ".rd1b"},  rd1_b,           exp_rd(ra1, 0));
    check_eq({tag, ".rd2b"},  rd2_b,           exp_rd(ra2, 0));
    check_eq({tag, ".rdy1a"}, DW'(rdy1_a),     exp_rdy(ra1, 1));
    check_eq({tag, ".rdy2a"}, DW'(rdy2_a),     exp_rdy(ra2, 1));
    check_eq({tag, ".rdy1b"}, DW'(rdy1_b),     exp_rdy(ra1, 0));
    check_eq({tag, ".rdy2b"}, DW'(rdy2_b),     exp_rdy(ra2, 0));
    check_eq({tag, ".cnta"},  DW'(pc_a),       exp_cnt());
    check_eq({tag, ".cntb"},  DW'(pc_b),       exp_cnt());
  endtask

  task automatic idle();
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    claim_en = 1'b0; claim_addr = '0;
  endtask

  // settle: sample combinational outputs mid-cycle; commit: take the edge.
  task automatic settle(input string tag);
    #2;
    check_all(tag);
  endtask

  task automatic commit();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    ra1 = '0; ra2 = '0;
    model_reset();

    // Reset state across every address.
    #2;
    for (int i = 0; i < DEPTH; i++) begin
      ra1 = AW'(i); ra2 = AW'(DEPTH - 1 - i);
      #1;
      check_eq("rst_rd1", rd1_a, '0);
      check_eq("rst_rdy1", DW'(rdy1_a), 1);
      check_all("rst");
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Write r5 through port 0, read it next cycle.
    we0 = 1'b1; wa0 = 5; wd0 = 32'hDEADBEEF; ra1 = 5; ra2 = 0;
    settle("w5"); commit();
    idle();
    settle("r5");
    check_eq("r5_rd1a", rd1_a, 32'hDEADBEEF);
    check_eq("r5_rd1b", rd1_b, 32'hDEADBEEF);
    commit();

    // Same-cycle write and read: bypass vs. one-cycle latency.
    we0 = 1'b1; wa0 = 3; wd0 = 32'h11; ra2 = 3;
    settle("w3");
    check_eq("w3_byp_rd2a", rd2_a, 32'h11);
    check_eq("w3_nobyp_rd2b", rd2_b, 32'h0);
    commit();
    idle();
    settle("r3");
    check_eq("r3_rd2b", rd2_b, 32'h11);
    commit();

    // Dual write to r7: port 1 wins, both for bypass and storage.
    we0 = 1'b1; wa0 = 7; wd0 = 32'hAAAA;
    we1 = 1'b1; wa1 = 7; wd1 = 32'h5555; ra1 = 7;
    settle("w7");
    check_eq("w7_byp_rd1a", rd1_a, 32'h5555);
    commit();
    idle();
    settle("r7");
    check_eq("r7_rd1b", rd1_b, 32'h5555);
    commit();

    // Register 0 ignores writes and claims.
    we0 = 1'b1; wa0 = 0; wd0 = 32'hFFFF; claim_en = 1'b1; claim_addr = 0; ra1 = 0;
    settle("w0");
    check_eq("w0_rd1a", rd1_a, '0);
    check_eq("w0_rdy1a", DW'(rdy1_a), 1);
    commit();
    idle();
    settle("r0");
    check_eq("r0_cnt", DW'(pc_a), 0);
    check_eq("r0_rd1b", rd1_b, '0);
    commit();

    // Scoreboard: claim r9, load returns a few cycles later.
    claim_en = 1'b1; claim_addr = 9; ra1 = 9;
    settle("c9"); commit();
    idle();
    settle("c9p");
    check_eq("c9_rdy1a", DW'(rdy1_a), 0);
    check_eq("c9_cnt", DW'(pc_a), 1);
    commit();
    settle("c9w1"); commit();
    settle("c9w2"); commit();
    we1 = 1'b1; wa1 = 9; wd1 = 32'h1234;
    settle("l9");
    check_eq("l9_rdy1a", DW'(rdy1_a), 1);
    check_eq("l9_rdy1b", DW'(rdy1_b), 0);
    commit();
    idle();
    settle("l9p");
    check_eq("l9_rd1a", rd1_a, 32'h1234);
    check_eq("l9_cnt", DW'(pc_a), 0);
    commit();
    // Claim and write together: the claim survives.
    claim_en = 1'b1; claim_addr = 9; we0 = 1'b1; wa0 = 9; wd0 = 32'h77;
    settle("cw9"); commit();
    idle();
    settle("cw9p");
    check_eq("cw9_cnt", DW'(pc_a), 1);
    check_eq("cw9_rdy1a", DW'(rdy1_a), 0);
    check_eq("cw9_rd1b", rd1_b, 32'h77);
    commit();
    // Re-claiming a pending register changes nothing.
    claim_en = 1'b1; claim_addr = 9;
    settle("rc9"); commit();
    idle();

    // Claim r1..r4, then reset asynchronously between edges.
    for (int i = 1; i <= 4; i++) begin
      claim_en = 1'b1; claim_addr = AW'(i);
      settle("cl"); commit();
    end
    idle();
    settle("cl5");
    check_eq("cl_cnt", DW'(pc_a), 5);
    we0 = 1'b1; wa0 = 2; wd0 = 32'hCAFE; ra1 = 2; ra2 = 9;
    claim_en = 1'b1; claim_addr = 6;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("arst_rd1a", rd1_a, '0);
    check_eq("arst_rdy2a", DW'(rdy2_a), 1);
    check_eq("arst_cnt", DW'(pc_a), 0);
    check_all("arst");
    commit();
    check_all("arst_edge");
    idle();
    rst_n = 1'b1;
    commit();
    for (int i = 0; i < DEPTH; i++) begin
      ra1 = AW'(i); ra2 = AW'(DEPTH - 1 - i);
      #1;
      check_all("post_rst");
    end
    check_eq("post_rst_cnt", DW'(pc_b), 0);
    commit();

    // Randomized traffic on a narrow address range to force collisions.
    for (int n = 0; n < 400; n++) begin
      ra1 = AW'($urandom_range(0, 15));
      ra2 = AW'($urandom_range(0, 15));
      we0 = 1'($urandom_range(0, 1));
      wa0 = AW'($urandom_range(0, 15));
      wd0 = $urandom;
      we1 = ($urandom_range(0, 2) == 0);
      wa1 = AW'($urandom_range(0, 15));
      wd1 = $urandom;
      claim_en = ($urandom_range(0, 2) == 0);
      claim_addr = AW'($urandom_range(0, 15));
      settle("rnd");
      commit();
    end
    idle();
    settle("end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
